// File: rtl/lia_magnitude.sv
// rtl/lia_magnitude.sv - lock-in amplitude R = floor(sqrt(I^2 + Q^2)), bit-serial restoring root
module lia_magnitude #(
  parameter int IN_W  = 25,
  parameter int SUM_W = 2 * IN_W,
  parameter int CNT_W = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic signed [IN_W-1:0] i_in,
  input  logic signed [IN_W-1:0] q_in,
  output logic                   busy,
  output logic [IN_W-1:0]        mag,
  output logic                   mag_valid,
  output logic                   overrun
);

  // Partial remainder never exceeds 2*root+1 before the final shift, so IN_W+2 bits suffice.
  localparam int REM_W = IN_W + 2;

  typedef enum logic [2:0] {IDLE, SQUARE, SUM, ROOT, DONE} state_t;

  state_t                 state_q, state_d;
  logic signed [IN_W-1:0] i_lat_q, i_lat_d;
  logic signed [IN_W-1:0] q_lat_q, q_lat_d;
  logic [SUM_W-2:0]       isq_q, isq_d;
  logic [SUM_W-2:0]       qsq_q, qsq_d;
  logic [SUM_W-1:0]       rad_q, rad_d;
  logic [REM_W-1:0]       rem_q, rem_d;
  logic [IN_W-1:0]        root_q, root_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IN_W-1:0]        mag_q, mag_d;
  logic                   mag_valid_q, mag_valid_d;
  logic                   overrun_q, overrun_d;

  // Signed squares: -2^(IN_W-1) squares to 2^(2*IN_W-2), which still fits in SUM_W-1 bits.
  logic signed [SUM_W-2:0] i_prod, q_prod;
  logic [REM_W-1:0]        rem_sh, trial;

  assign i_prod = i_lat_q * i_lat_q;
  assign q_prod = q_lat_q * q_lat_q;
  assign rem_sh = (rem_q << 2) | REM_W'(rad_q[SUM_W-1 -: 2]);
  assign trial  = (REM_W'(root_q) << 2) | REM_W'(1);

  always_comb begin
    state_d     = state_q;
    i_lat_d     = i_lat_q;
    q_lat_d     = q_lat_q;
    isq_d       = isq_q;
    qsq_d       = qsq_q;
    rad_d       = rad_q;
    rem_d       = rem_q;
    root_d      = root_q;
    cnt_d       = cnt_q;
    mag_d       = mag_q;
    mag_valid_d = 1'b0;
    overrun_d   = in_valid && (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          i_lat_d = i_in;
          q_lat_d = q_in;
          state_d = SQUARE;
        end
      end
      SQUARE: begin
        isq_d   = i_prod;
        qsq_d   = q_prod;
        state_d = SUM;
      end
      SUM: begin
        rad_d   = SUM_W'(isq_q) + SUM_W'(qsq_q);
        rem_d   = '0;
        root_d  = '0;
        cnt_d   = CNT_W'(IN_W - 1);
        state_d = ROOT;
      end
      ROOT: begin
        rad_d = rad_q << 2;
        if (rem_sh >= trial) begin
          rem_d  = rem_sh - trial;
          root_d = (root_q << 1) | IN_W'(1);
        end else begin
          rem_d  = rem_sh;
          root_d = root_q << 1;
        end
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DONE: begin
        mag_d       = root_q;
        mag_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      i_lat_q     <= '0;
      q_lat_q     <= '0;
      isq_q       <= '0;
      qsq_q       <= '0;
      rad_q       <= '0;
      rem_q       <= '0;
      root_q      <= '0;
      cnt_q       <= '0;
      mag_q       <= '0;
      mag_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_lat_q     <= i_lat_d;
      q_lat_q     <= q_lat_d;
      isq_q       <= isq_d;
      qsq_q       <= qsq_d;
      rad_q       <= rad_d;
      rem_q       <= rem_d;
      root_q      <= root_d;
      cnt_q       <= cnt_d;
      mag_q       <= mag_d;
      mag_valid_q <= mag_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign mag       = mag_q;
  assign mag_valid = mag_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_lia_magnitude.sv
// tb/tb_lia_magnitude.sv - scoreboard bench for lia_magnitude against a floor-sqrt model
module tb_lia_magnitude;
  localparam int IN_W = 25;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   in_valid = 1'b0;
  logic signed [IN_W-1:0] i_in = '0;
  logic signed [IN_W-1:0] q_in = '0;
  logic                   busy;
  logic [IN_W-1:0]        mag;
  logic                   mag_valid;
  logic                   overrun;

  lia_magnitude #(.IN_W(IN_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .i_in(i_in), .q_in(q_in),
    .busy(busy), .mag(mag), .mag_valid(mag_valid), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int    n_pass = 0;
  int    n_total = 0;
  int    ov_count = 0;
  longint exp_q[$];
  longint hold_exp = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic longint ref_mag(input longint i, input longint q);
    longint s, r;
    s = i * i + q * q;
    r = longint'($sqrt(real'(s)));
    while (r * r > s) r--;
    while ((r + 1) * (r + 1) <= s) r++;
    return r;
  endfunction

  // Monitor: pops the scoreboard on every result and checks that mag holds in between.
  always @(negedge clk) begin
    if (!rst) begin
      if (overrun) ov_count++;
      if (mag_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_mag_valid", 1, 0);
        end else begin
          hold_exp = exp_q.pop_front();
          check("mag", longint'(mag), hold_exp);
        end
      end else begin
        check("mag_hold", longint'(mag), hold_exp);
      end
    end
  end

  // Caller sits on a negedge; the strobe is sampled at the next posedge.
  task automatic strobe(input logic signed [IN_W-1:0] i, input logic signed [IN_W-1:0] q);
    in_valid = 1'b1;
    i_in     = i;
    q_in     = q;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send(input logic signed [IN_W-1:0] i, input logic signed [IN_W-1:0] q);
    exp_q.push_back(ref_mag(longint'(i), longint'(q)));
    strobe(i, q);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("wait_idle_timeout", t, 0);
  endtask

  task automatic timed(input logic signed [IN_W-1:0] i, input logic signed [IN_W-1:0] q);
    int lat = 0;
    int busy_low = 0;
    send(i, q);
    while (!mag_valid && lat < 40) begin
      if (!busy) busy_low++;
      @(negedge clk);
      lat++;
    end
    check("latency", lat, IN_W + 3);
    check("busy_during_compute", busy_low, 0);
    check("busy_after_done", busy, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic signed [IN_W-1:0] ri, rq;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_mag", mag, 0);
    check("reset_mag_valid", mag_valid, 0);
    check("reset_overrun", overrun, 0);
    rst = 1'b0;
    @(negedge clk);

    timed(25'sd3, 25'sd4);
    @(negedge clk);
    send(-25'sd3, -25'sd4);     wait_idle();
    send(25'sd1, 25'sd1);       wait_idle();
    send(25'sd0, 25'sd0);       wait_idle();
    send(25'sd1000, -25'sd1000); wait_idle();
    send(-25'sd16777216, -25'sd16777216); wait_idle();
    send(25'sd16777215, 25'sd0); wait_idle();

    // Overrun: second strobe five edges after the first is dropped.
    send(25'sd6, 25'sd8);
    repeat (4) @(negedge clk);
    strobe(25'sd100, 25'sd0);
    check("overrun_pulse", overrun, 1);
    @(negedge clk);
    check("overrun_single", overrun, 0);
    wait_idle();
    // Re-entry: strobe on the edge right after DONE must be accepted.
    timed(25'sd9, 25'sd12);
    @(negedge clk);

    // Reset mid-ROOT aborts the computation.
    send(25'sd7, 25'sd24);
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    hold_exp = 0;
    check("midreset_busy", busy, 0);
    check("midreset_mag", mag, 0);
    check("midreset_mag_valid", mag_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (35) @(negedge clk);
    timed(25'sd5, 25'sd12);
    @(negedge clk);

    for (int n = 0; n < 1500; n++) begin
      ri = IN_W'($urandom);
      rq = IN_W'($urandom);
      if (n % 50 == 0) ri = -25'sd16777216;
      if (n % 70 == 0) rq = 25'sd16777215;
      if (n % 90 == 0) ri = 25'sd0;
      send(ri, rq);
      wait_idle();
    end
    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    check("overrun_count", ov_count, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
